// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: instruction-memory req/ack bus between the fetch unit and memory
interface instruction_fetch_unit_if;
  logic        IMem_Req;
  logic [31:0] IMem_Addr;
  logic        IMem_Ack;
  logic [31:0] IMem_Data;
  modport master (output IMem_Req, IMem_Addr, input IMem_Ack, IMem_Data);
  modport slave (input IMem_Req, IMem_Addr, output IMem_Ack, IMem_Data);
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetches instructions over req/ack, holds them and splits out decode fields
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             Enable_i,
  input  logic                             Stall_i,
  instruction_fetch_unit_if.master         imem,
  output logic                             Instr_Valid_o,
  output logic [31:0]                      PC_o,
  output logic [6:0]                       Opcode_o,
  output logic [4:0]                       Rd_o,
  output logic [2:0]                       Funct_Tres_o,
  output logic [4:0]                       Rs1_o,
  output logic [4:0]                       Rs2_o,
  output logic [6:0]                       Funct_Siete_o,
  output logic [31:0]                      Imm_I_o,
  output logic [31:0]                      Imm_S_o,
  output logic [31:0]                      Imm_U_o,
  output logic                             Fault_o
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;
  logic [1:0]  state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [6:0]  op_in;
  logic        legal;
  logic        take;
  assign op_in = imem.IMem_Data[6:0];
  assign legal = op_in == 7'b0110011 || op_in == 7'b0100011 || op_in == 7'b0110111 ||
                 op_in == 7'b0010011 || op_in == 7'b0000011;
  assign take  = state_q == FETCH && imem.IMem_Ack;
  // next state: Ack only matters in FETCH, Stall only in HOLD, FAULT is left only by reset
  always_comb begin
    state_d = state_q == IDLE  ? (Enable_i ? FETCH : IDLE) :
              state_q == FETCH ? (!imem.IMem_Ack ? FETCH : legal ? HOLD : FAULT) :
              state_q == HOLD  ? (Stall_i ? HOLD : Enable_i ? FETCH : IDLE) : FAULT;
    ir_d    = take ? imem.IMem_Data : ir_q;
    pc_d    = take ? addr_q : pc_q;
    addr_d  = take ? addr_q + 32'd4 : addr_q;
  end
  // state, instruction register, held PC and next fetch address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ir_q    <= '0;
      pc_q    <= '0;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end
  assign imem.IMem_Req  = state_q == FETCH;
  assign imem.IMem_Addr = addr_q;
  assign Instr_Valid_o  = state_q == HOLD;
  assign Fault_o        = state_q == FAULT;
  assign PC_o           = pc_q;
  assign Opcode_o       = ir_q[6:0];
  assign Rd_o           = ir_q[11:7];
  assign Funct_Tres_o   = ir_q[14:12];
  assign Rs1_o          = ir_q[19:15];
  assign Rs2_o          = ir_q[24:20];
  assign Funct_Siete_o  = ir_q[31:25];
  assign Imm_I_o        = {{20{ir_q[31]}}, ir_q[31:20]};
  assign Imm_S_o        = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign Imm_U_o        = {ir_q[31:12], 12'b0};
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed vector and sequence checks for the fetch unit
module tb_instruction_fetch_unit;
  logic clk, rst_n, en, stall, en2, stall2;
  logic        valid, fault, valid2, fault2;
  logic [31:0] pc, imm_i, imm_s, imm_u, pc2, imm_i2, imm_s2, imm_u2;
  logic [6:0]  op, f7, op2, f72;
  logic [4:0]  rd, rs1, rs2, rd2, rs12, rs22;
  logic [2:0]  f3, f32;
  int checks = 0;
  int errors = 0;
  int exp_pc;
  typedef struct {
    logic [31:0] instr;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
  } vec_t;
  vec_t vecs [5];
  instruction_fetch_unit_if bus ();
  instruction_fetch_unit_if bus2 ();
  instruction_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .Enable_i(en), .Stall_i(stall), .imem(bus),
    .Instr_Valid_o(valid), .PC_o(pc), .Opcode_o(op), .Rd_o(rd), .Funct_Tres_o(f3),
    .Rs1_o(rs1), .Rs2_o(rs2), .Funct_Siete_o(f7), .Imm_I_o(imm_i), .Imm_S_o(imm_s),
    .Imm_U_o(imm_u), .Fault_o(fault)
  );
  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst_n(rst_n), .Enable_i(en2), .Stall_i(stall2), .imem(bus2),
    .Instr_Valid_o(valid2), .PC_o(pc2), .Opcode_o(op2), .Rd_o(rd2), .Funct_Tres_o(f32),
    .Rs1_o(rs12), .Rs2_o(rs22), .Funct_Siete_o(f72), .Imm_I_o(imm_i2), .Imm_S_o(imm_s2),
    .Imm_U_o(imm_u2), .Fault_o(fault2)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  initial begin
    vecs[0] = '{32'h00A00093, 7'b0010011, 5'd1,  3'd0, 5'd0, 5'd10, 7'h00, 32'h0000000A, 32'h00000001, 32'h00A00000};
    vecs[1] = '{32'hFE112E23, 7'b0100011, 5'd28, 3'd2, 5'd2, 5'd1,  7'h7F, 32'hFFFFFFE1, 32'hFFFFFFFC, 32'hFE112000};
    vecs[2] = '{32'h123450B7, 7'b0110111, 5'd1,  3'd5, 5'd8, 5'd3,  7'h09, 32'h00000123, 32'h00000121, 32'h12345000};
    vecs[3] = '{32'h00412183, 7'b0000011, 5'd3,  3'd2, 5'd2, 5'd4,  7'h00, 32'h00000004, 32'h00000003, 32'h00412000};
    vecs[4] = '{32'h407302B3, 7'b0110011, 5'd5,  3'd0, 5'd6, 5'd7,  7'h20, 32'h00000407, 32'h00000405, 32'h40730000};
    rst_n = 0; en = 0; stall = 0; en2 = 0; stall2 = 0;
    bus.IMem_Ack = 0; bus.IMem_Data = '0; bus2.IMem_Ack = 0; bus2.IMem_Data = '0;
    step();
    chk("rst_req", bus.IMem_Req, 0);
    chk("rst_addr", bus.IMem_Addr, 0);
    chk("rst_valid", valid, 0);
    chk("rst_fault", fault, 0);
    chk("rst_pc", pc, 0);
    chk("rst_imm_i", imm_i, 0);
    chk("rst_addr2", bus2.IMem_Addr, 32'hFFFF_FFFC);
    rst_n = 1;
    en = 1;
    step();
    exp_pc = 0;
    for (int i = 0; i < 5; i++) begin
      chk("fetch_req", bus.IMem_Req, 1);
      chk("fetch_addr", bus.IMem_Addr, exp_pc);
      bus.IMem_Ack = 1;
      bus.IMem_Data = vecs[i].instr;
      step();
      bus.IMem_Ack = 0;
      chk("hold_valid", valid, 1);
      chk("hold_req", bus.IMem_Req, 0);
      chk("hold_pc", pc, exp_pc);
      chk("next_addr", bus.IMem_Addr, exp_pc + 4);
      chk("opcode", op, vecs[i].op);
      chk("rd", rd, vecs[i].rd);
      chk("funct3", f3, vecs[i].f3);
      chk("rs1", rs1, vecs[i].rs1);
      chk("rs2", rs2, vecs[i].rs2);
      chk("funct7", f7, vecs[i].f7);
      chk("imm_i", imm_i, vecs[i].imm_i);
      chk("imm_s", imm_s, vecs[i].imm_s);
      chk("imm_u", imm_u, vecs[i].imm_u);
      exp_pc += 4;
      step();
    end
    chk("stall_fetch_addr", bus.IMem_Addr, 20);
    bus.IMem_Ack = 1;
    bus.IMem_Data = 32'h123450B7;
    stall = 1;
    step();
    bus.IMem_Ack = 0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", valid, 1);
      chk("stall_req", bus.IMem_Req, 0);
      chk("stall_imm_u", imm_u, 32'h12345000);
      chk("stall_rd", rd, 1);
      chk("stall_pc", pc, 20);
      step();
    end
    stall = 0;
    chk("stall_end_valid", valid, 1);
    step();
    chk("post_stall_req", bus.IMem_Req, 1);
    chk("post_stall_addr", bus.IMem_Addr, 24);
    chk("post_stall_valid", valid, 0);
    step();
    chk("wait1_req", bus.IMem_Req, 1);
    en = 0;
    step();
    chk("wait2_req", bus.IMem_Req, 1);
    step();
    chk("wait3_req", bus.IMem_Req, 1);
    bus.IMem_Ack = 1;
    bus.IMem_Data = 32'h00412183;
    step();
    bus.IMem_Ack = 0;
    chk("late_valid", valid, 1);
    chk("late_pc", pc, 24);
    chk("late_rd", rd, 3);
    step();
    chk("idle_valid", valid, 0);
    chk("idle_req", bus.IMem_Req, 0);
    bus.IMem_Ack = 1;
    bus.IMem_Data = 32'hFFFFFFFF;
    step();
    bus.IMem_Ack = 0;
    chk("idle_ack_rd", rd, 3);
    chk("idle_ack_pc", pc, 24);
    chk("idle_ack_addr", bus.IMem_Addr, 28);
    chk("idle_ack_req", bus.IMem_Req, 0);
    en = 1;
    step();
    chk("jal_req", bus.IMem_Req, 1);
    bus.IMem_Ack = 1;
    bus.IMem_Data = 32'h0000006F;
    step();
    bus.IMem_Data = 32'h00A00093;
    for (int i = 0; i < 3; i++) begin
      chk("fault_flag", fault, 1);
      chk("fault_valid", valid, 0);
      chk("fault_req", bus.IMem_Req, 0);
      chk("fault_pc", pc, 28);
      chk("fault_opcode", op, 7'b1101111);
      step();
    end
    bus.IMem_Ack = 0;
    rst_n = 0;
    #1;
    chk("clr_fault", fault, 0);
    chk("clr_addr", bus.IMem_Addr, 0);
    chk("clr_pc", pc, 0);
    chk("clr_opcode", op, 0);
    step();
    rst_n = 1;
    step();
    chk("refetch_req", bus.IMem_Req, 1);
    bus.IMem_Ack = 1;
    rst_n = 0;
    #1;
    chk("rst_mid_req", bus.IMem_Req, 0);
    step();
    bus.IMem_Ack = 0;
    rst_n = 1;
    en = 0;
    chk("rst_mid_valid", valid, 0);
    chk("rst_mid_opcode", op, 0);
    chk("rst_mid_addr", bus.IMem_Addr, 0);
    en2 = 1;
    step();
    chk("wrap_req", bus2.IMem_Req, 1);
    chk("wrap_fetch_addr", bus2.IMem_Addr, 32'hFFFF_FFFC);
    bus2.IMem_Ack = 1;
    bus2.IMem_Data = 32'h00A00093;
    step();
    bus2.IMem_Ack = 0;
    en2 = 0;
    chk("wrap_valid", valid2, 1);
    chk("wrap_pc", pc2, 32'hFFFF_FFFC);
    chk("wrap_addr", bus2.IMem_Addr, 0);
    chk("wrap_fault", fault2, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
